shadow_register_bank: RTL and testbench

Parametrised, double-buffered successor of the rasterizer's register bank. Fills a shadow copy of the bank from an AXI-Stream command beat sequence and atomically commits it to the active copy only when the consumer signals it is idle. Downstream pipelines therefore never see a half-written bank. It sits between the command parser and the rasterizer/texture units that consume the bank as flat register vectors.

---
 rtl/shadow_register_bank_pkg.sv | 16 +
 rtl/shadow_bank_writer.sv | 120 ++++++++++++
 rtl/shadow_register_bank.sv | 94 +++++++++
 tb/tb_shadow_register_bank.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shadow_register_bank_pkg.sv
// Shared types and defaults for the double-buffered register bank.
package shadow_register_bank_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  localparam int          DEFAULT_REG_WIDTH   = 32;
  localparam logic [31:0] DEFAULT_RESET_VALUE = 32'h0000_0000;

  function automatic int regs_per_beat(input int stream_w, input int reg_w);
    return stream_w / reg_w;
  endfunction

endpackage

// File: rtl/shadow_bank_writer.sv
// Shadow storage plus write index; out-of-range handling selected by
// SHADOW_BANK_OVERFLOW_CHECK_EN (drop + sticky flag) or default wrap.
module shadow_bank_writer
  import shadow_register_bank_pkg::*;
#(
  parameter int                    BANK_SIZE        = 8,
  parameter int                    REG_WIDTH        = DEFAULT_REG_WIDTH,
  parameter int                    CMD_STREAM_WIDTH = 32,
  parameter logic [REG_WIDTH-1:0]  RESET_VALUE      = REG_WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic                            aclk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [CMD_STREAM_WIDTH-1:0]     wr_data,
  input  logic                            clear_idx,
  output logic [BANK_SIZE*REG_WIDTH-1:0]  shadow,
  output logic                            overflow
);

  localparam int RPB   = regs_per_beat(CMD_STREAM_WIDTH, REG_WIDTH);
  localparam int IDX_W = $clog2(BANK_SIZE) + 1;
  localparam int SUM_W = IDX_W + 1;

  typedef logic [SUM_W-1:0] sum_t;

  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic [REG_WIDTH-1:0] shadow_q [BANK_SIZE];
  logic [REG_WIDTH-1:0] wr_val   [BANK_SIZE];
  logic [BANK_SIZE-1:0] wr_hit;
`ifdef SHADOW_BANK_OVERFLOW_CHECK_EN
  logic                 beat_ovf;
  logic                 ovf_q;
`endif

  // Map each register slot of the beat onto its target shadow register.
  always_comb begin
    sum_t tgt;
    sum_t nxt;
    wr_hit = '0;
`ifdef SHADOW_BANK_OVERFLOW_CHECK_EN
    beat_ovf = 1'b0;
`endif
    for (int k = 0; k < BANK_SIZE; k++) begin
      wr_val[k] = '0;
    end
    for (int i = 0; i < RPB; i++) begin
      tgt = sum_t'(idx_q) + sum_t'(i);
`ifdef SHADOW_BANK_OVERFLOW_CHECK_EN
      if (tgt >= sum_t'(BANK_SIZE)) begin
        beat_ovf = 1'b1;
      end
`else
      if (tgt >= sum_t'(BANK_SIZE)) begin
        tgt = tgt - sum_t'(BANK_SIZE);
      end
`endif
      // An out-of-range target matches no slot and is simply dropped.
      for (int k = 0; k < BANK_SIZE; k++) begin
        if (tgt == sum_t'(k)) begin
          wr_hit[k] = 1'b1;
          wr_val[k] = wr_data[REG_WIDTH*i +: REG_WIDTH];
        end
      end
    end

    nxt = sum_t'(idx_q) + sum_t'(RPB);
`ifdef SHADOW_BANK_OVERFLOW_CHECK_EN
    if (nxt >= sum_t'(BANK_SIZE)) begin
      nxt = sum_t'(BANK_SIZE);
    end
`else
    if (nxt >= sum_t'(BANK_SIZE)) begin
      nxt = nxt - sum_t'(BANK_SIZE);
    end
`endif
    idx_d = IDX_W'(nxt);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      idx_q <= '0;
      for (int k = 0; k < BANK_SIZE; k++) begin
        shadow_q[k] <= RESET_VALUE;
      end
    end else begin
      if (clear_idx) begin
        idx_q <= '0;
      end else if (wr_en) begin
        idx_q <= idx_d;
      end
      if (wr_en) begin
        for (int k = 0; k < BANK_SIZE; k++) begin
          if (wr_hit[k]) begin
            shadow_q[k] <= wr_val[k];
          end
        end
      end
    end
  end

`ifdef SHADOW_BANK_OVERFLOW_CHECK_EN
  always_ff @(posedge aclk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (wr_en && beat_ovf) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  for (genvar g = 0; g < BANK_SIZE; g++) begin : g_flat
    assign shadow[REG_WIDTH*g +: REG_WIDTH] = shadow_q[g];
  end

endmodule

// File: rtl/shadow_register_bank.sv
// Double-buffered register bank: AXI-Stream fills the shadow copy, which is
// committed atomically when the consumer is idle. Optional macro:
// SHADOW_BANK_OVERFLOW_CHECK_EN.
module shadow_register_bank
  import shadow_register_bank_pkg::*;
#(
  parameter int                    BANK_SIZE        = 8,
  parameter int                    REG_WIDTH        = DEFAULT_REG_WIDTH,
  parameter int                    CMD_STREAM_WIDTH = 32,
  parameter logic [REG_WIDTH-1:0]  RESET_VALUE      = REG_WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic                            aclk,
  input  logic                            reset,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic [CMD_STREAM_WIDTH-1:0]     s_axis_tdata,
  input  logic                            commit_ready,
  output logic [BANK_SIZE*REG_WIDTH-1:0]  registers,
  output logic                            registers_updated,
  output logic                            overflow
);

  state_e                          state_q;
  state_e                          state_d;
  logic                            tready_q;
  logic                            accept;
  logic                            commit;
  logic [BANK_SIZE*REG_WIDTH-1:0]  shadow;
  logic [BANK_SIZE*REG_WIDTH-1:0]  active_q;
  logic                            updated_q;

  assign accept = s_axis_tvalid && tready_q;

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept && s_axis_tlast) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (commit_ready) begin
          commit  = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // tready is registered from the next state so it tracks (state == FILL).
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q   <= FILL;
      tready_q  <= 1'b1;
      updated_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tready_q  <= (state_d == FILL);
      updated_q <= commit;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      active_q <= {BANK_SIZE{RESET_VALUE}};
    end else if (commit) begin
      active_q <= shadow;
    end
  end

  shadow_bank_writer #(
    .BANK_SIZE        (BANK_SIZE),
    .REG_WIDTH        (REG_WIDTH),
    .CMD_STREAM_WIDTH (CMD_STREAM_WIDTH),
    .RESET_VALUE      (RESET_VALUE)
  ) u_writer (
    .aclk      (aclk),
    .reset     (reset),
    .wr_en     (accept),
    .wr_data   (s_axis_tdata),
    .clear_idx (commit),
    .shadow    (shadow),
    .overflow  (overflow)
  );

  assign s_axis_tready     = tready_q;
  assign registers         = active_q;
  assign registers_updated = updated_q;

endmodule

// File: tb/tb_shadow_register_bank.sv
// Directed bench for shadow_register_bank: 32-bit and 64-bit stream instances.
module tb_shadow_register_bank;

  logic aclk = 1'b0;
  logic reset;

  logic        tvalid32, tlast32, cr32, tready32, upd32, ovf32;
  logic [31:0] tdata32;
  logic [255:0] regs32;
  logic        tvalid64, tlast64, cr64, tready64, upd64, ovf64;
  logic [63:0] tdata64;
  logic [255:0] regs64;

  logic [31:0] reg32 [8];
  logic [31:0] reg64 [8];
  logic [31:0] exp32 [8];
  logic [31:0] exp64 [8];

  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  shadow_register_bank #(.BANK_SIZE(8), .REG_WIDTH(32), .CMD_STREAM_WIDTH(32), .RESET_VALUE(32'h0)) dut32 (
    .aclk(aclk), .reset(reset),
    .s_axis_tvalid(tvalid32), .s_axis_tready(tready32), .s_axis_tlast(tlast32), .s_axis_tdata(tdata32),
    .commit_ready(cr32), .registers(regs32), .registers_updated(upd32), .overflow(ovf32)
  );

  shadow_register_bank #(.BANK_SIZE(8), .REG_WIDTH(32), .CMD_STREAM_WIDTH(64), .RESET_VALUE(32'h0)) dut64 (
    .aclk(aclk), .reset(reset),
    .s_axis_tvalid(tvalid64), .s_axis_tready(tready64), .s_axis_tlast(tlast64), .s_axis_tdata(tdata64),
    .commit_ready(cr64), .registers(regs64), .registers_updated(upd64), .overflow(ovf64)
  );

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      reg32[k] = regs32[32*k +: 32];
      reg64[k] = regs64[32*k +: 32];
    end
  end

  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [31:0] tdata;
    logic        cr;
    logic        exp_tready;
    logic        exp_upd;
    logic [31:0] exp_r0;
    logic [31:0] exp_r7;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_bank32(input string name);
    for (int k = 0; k < 8; k++) chk($sformatf("%s.r%0d", name, k), reg32[k], exp32[k]);
  endtask

  task automatic chk_bank64(input string name);
    for (int k = 0; k < 8; k++) chk($sformatf("%s.r%0d", name, k), reg64[k], exp64[k]);
  endtask

  task automatic drive32(input logic v, input logic l, input logic [31:0] d, input logic c);
    tvalid32 = v; tlast32 = l; tdata32 = d; cr32 = c;
  endtask

  task automatic drive64(input logic v, input logic l, input logic [63:0] d, input logic c);
    tvalid64 = v; tlast64 = l; tdata64 = d; cr64 = c;
  endtask

  initial begin
    // {tvalid, tlast, tdata, commit_ready, exp_tready, exp_upd, exp_r0, exp_r7}
    tbl[0]  = '{1'b1, 1'b0, 32'h10, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h12, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'hEE, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h13, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h14, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h15, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h16, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[8]  = '{1'b1, 1'b1, 32'h17, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h10, 32'h17};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h10, 32'h17};
    tbl[11] = '{1'b1, 1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 32'h10, 32'h17};
    tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h77, 32'h17};
    tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h77, 32'h17};

    reset = 1'b1;
    drive32(1'b0, 1'b0, 32'h0, 1'b0);
    drive64(1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    for (int k = 0; k < 8; k++) begin
      exp32[k] = 32'h0;
      exp64[k] = 32'h0;
    end
    chk("rst.tready32", {31'b0, tready32}, 32'd1);
    chk("rst.upd32", {31'b0, upd32}, 32'd0);
    chk("rst.ovf32", {31'b0, ovf32}, 32'd0);
    chk("rst.tready64", {31'b0, tready64}, 32'd1);
    chk("rst.upd64", {31'b0, upd64}, 32'd0);
    chk_bank32("rst.bank32");
    chk_bank64("rst.bank64");

    // Table: full packet with a tlast-only idle gap, then a one-beat partial packet
    for (int i = 0; i < 14; i++) begin
      drive32(tbl[i].tvalid, tbl[i].tlast, tbl[i].tdata, tbl[i].cr);
      tick();
      chk($sformatf("tbl%0d.tready", i), {31'b0, tready32}, {31'b0, tbl[i].exp_tready});
      chk($sformatf("tbl%0d.upd", i), {31'b0, upd32}, {31'b0, tbl[i].exp_upd});
      chk($sformatf("tbl%0d.r0", i), reg32[0], tbl[i].exp_r0);
      chk($sformatf("tbl%0d.r7", i), reg32[7], tbl[i].exp_r7);
    end
    exp32[0] = 32'h77;
    for (int k = 1; k < 8; k++) exp32[k] = 32'h10 + k;
    chk_bank32("tbl.bank");

    // Stalled commit: commit_ready low for 5 cycles after tlast
    for (int k = 0; k < 8; k++) begin
      drive32(1'b1, (k == 7), 32'h20 + k, 1'b0);
      tick();
    end
    chk("stall.tready_drop", {31'b0, tready32}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      drive32(1'b1, 1'b0, 32'hDEAD, 1'b0);
      tick();
      chk($sformatf("stall%0d.tready", c), {31'b0, tready32}, 32'd0);
      chk($sformatf("stall%0d.upd", c), {31'b0, upd32}, 32'd0);
      chk_bank32($sformatf("stall%0d.bank", c));
    end
    drive32(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) exp32[k] = 32'h20 + k;
    chk("stall.commit_upd", {31'b0, upd32}, 32'd1);
    chk("stall.commit_tready", {31'b0, tready32}, 32'd1);
    chk_bank32("stall.commit_bank");
    tick();
    chk("stall.upd_width", {31'b0, upd32}, 32'd0);

    // 64-bit stream: fill with 0xFF, then a 2-beat prefix packet
    for (int b = 0; b < 4; b++) begin
      drive64(1'b1, (b == 3), 64'h0000_00FF_0000_00FF, 1'b1);
      tick();
    end
    drive64(1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    chk("w64.fill_upd", {31'b0, upd64}, 32'd1);
    for (int k = 0; k < 8; k++) exp64[k] = 32'hFF;
    chk_bank64("w64.fill");
    drive64(1'b1, 1'b0, 64'h0000_00A1_0000_00A0, 1'b1);
    tick();
    drive64(1'b1, 1'b1, 64'h0000_00B1_0000_00B0, 1'b1);
    tick();
    chk("w64.tready_drop", {31'b0, tready64}, 32'd0);
    drive64(1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    chk("w64.upd", {31'b0, upd64}, 32'd1);
    exp64[0] = 32'hA0; exp64[1] = 32'hA1; exp64[2] = 32'hB0; exp64[3] = 32'hB1;
    chk_bank64("w64.prefix");

    // 10-beat packet into an 8-register bank
    for (int j = 0; j < 10; j++) begin
      drive32(1'b1, (j == 9), 32'h30 + j, 1'b1);
      tick();
    end
    drive32(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("ovf.upd", {31'b0, upd32}, 32'd1);
    for (int k = 0; k < 8; k++) exp32[k] = 32'h30 + k;
`ifdef SHADOW_BANK_OVERFLOW_CHECK_EN
    chk("ovf.flag", {31'b0, ovf32}, 32'd1);
`else
    exp32[0] = 32'h38;
    exp32[1] = 32'h39;
    chk("ovf.flag", {31'b0, ovf32}, 32'd0);
`endif
    chk_bank32("ovf.bank");
    drive32(1'b1, 1'b1, 32'h40, 1'b1);
    tick();
    drive32(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    exp32[0] = 32'h40;
    chk_bank32("ovf.next_pkt");
`ifdef SHADOW_BANK_OVERFLOW_CHECK_EN
    chk("ovf.sticky", {31'b0, ovf32}, 32'd1);
`else
    chk("ovf.sticky", {31'b0, ovf32}, 32'd0);
`endif

    // Reset on beat 3 of a packet
    for (int j = 0; j < 3; j++) begin
      drive32(1'b1, 1'b0, 32'h50 + j, 1'b1);
      tick();
    end
    drive32(1'b1, 1'b0, 32'h53, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive32(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++) exp32[k] = 32'h0;
    chk("rstmid.tready", {31'b0, tready32}, 32'd1);
    chk("rstmid.upd", {31'b0, upd32}, 32'd0);
    chk("rstmid.ovf", {31'b0, ovf32}, 32'd0);
    chk_bank32("rstmid.bank");
    tick();
    chk("rstmid.no_strobe", {31'b0, upd32}, 32'd0);

    // Reset while a commit is pending
    drive32(1'b1, 1'b1, 32'h58, 1'b0);
    tick();
    chk("rstcm.tready_drop", {31'b0, tready32}, 32'd0);
    drive32(1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive32(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("rstcm.upd", {31'b0, upd32}, 32'd0);
    chk("rstcm.tready", {31'b0, tready32}, 32'd1);
    chk_bank32("rstcm.bank");

    // Fresh packet after reset
    for (int k = 0; k < 8; k++) begin
      drive32(1'b1, (k == 7), 32'h60 + k, 1'b1);
      tick();
    end
    drive32(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("fresh.upd", {31'b0, upd32}, 32'd1);
    for (int k = 0; k < 8; k++) exp32[k] = 32'h60 + k;
    chk_bank32("fresh.bank");
    tick();
    chk("fresh.upd_width", {31'b0, upd32}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
